// File: rtl/dot_field.sv
// dot_field: owns the ten collectible maze dots.
// Combinational per-pixel hit test against fixed dot centres, plus a
// registered alive mask that only ever clears as dots are eaten.
module dot_field #(
   parameter int NUM_DOTS = 10,
   parameter int DOT_HALF = 3
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic [9:0]          DrawX,
   input  logic [9:0]          DrawY,
   input  logic [NUM_DOTS-1:0] kill_10,
   output logic [NUM_DOTS-1:0] is_dot,
   output logic                is_dots,
   output logic [3:0]          dot_number,
   output logic [NUM_DOTS-1:0] alive_10,
   output logic [3:0]          alive_count,
   output logic                all_eaten
);

   // Half-width in the signed difference domain.
   localparam logic signed [10:0] HALF = 11'(DOT_HALF);

   // Fixed dot centre column by dot index.
   function automatic logic [9:0] dot_x(input int idx);
      logic [9:0] v;
      case (idx)
         0, 3, 7: v = 10'd40;
         1, 8:    v = 10'd320;
         4:       v = 10'd180;
         5:       v = 10'd460;
         2, 6, 9: v = 10'd600;
         default: v = 10'd0;
      endcase
      return v;
   endfunction

   // Fixed dot centre row by dot index.
   function automatic logic [9:0] dot_y(input int idx);
      logic [9:0] v;
      case (idx)
         0, 1, 2:       v = 10'd40;
         3, 4, 5, 6:    v = 10'd240;
         7, 8, 9:       v = 10'd440;
         default:       v = 10'd0;
      endcase
      return v;
   endfunction

   // One square test per dot. Differences are taken in 11-bit signed so large
   // coordinates (e.g. 1023) can never wrap into a near-zero distance.
   for (genvar gi = 0; gi < NUM_DOTS; gi++) begin : g_hit
      logic signed [10:0] dx;
      logic signed [10:0] dy;
      assign dx = $signed({1'b0, DrawX}) - $signed({1'b0, dot_x(gi)});
      assign dy = $signed({1'b0, DrawY}) - $signed({1'b0, dot_y(gi)});
      assign is_dot[gi] = (dx >= -HALF) && (dx <= HALF) &&
                          (dy >= -HALF) && (dy <= HALF);
   end

   assign is_dots = |is_dot;

   // Binary index of the hit dot; scanning downward makes the lowest hit win.
   always_comb begin
      dot_number = 4'd0;
      for (int i = NUM_DOTS - 1; i >= 0; i--) begin
         if (is_dot[i]) begin
            dot_number = 4'(i);
         end
      end
   end

   // Alive mask: reset restores every dot (and overrides a same-cycle kill);
   // otherwise named dots are cleared, and cleared dots stay cleared.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         alive_10 <= '1;
      end else begin
         alive_10 <= alive_10 & ~kill_10;
      end
   end

   // Number of dots still alive.
   always_comb begin
      alive_count = 4'd0;
      for (int i = 0; i < NUM_DOTS; i++) begin
         alive_count = alive_count + 4'(alive_10[i]);
      end
   end

   assign all_eaten = (alive_10 == '0);

endmodule

// File: tb/tb_dot_field.sv
// Self-checking bench for dot_field: directed hit points, alive-mask
// scenarios, randomized kills/coordinates and a full-frame sweep, all
// compared against a behavioural model of the dot layout and eat rules.
module tb_dot_field;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic [9:0] kill_10;
   logic [9:0] is_dot;
   logic       is_dots;
   logic [3:0] dot_number;
   logic [9:0] alive_10;
   logic [3:0] alive_count;
   logic       all_eaten;

   int tests = 0;
   int fails = 0;

   // Model state: which dots are still uneaten.
   logic [9:0] alive_model;

   int cx [10] = '{40, 320, 600, 40, 180, 460, 600, 40, 320, 600};
   int cy [10] = '{40, 40, 40, 240, 240, 240, 240, 440, 440, 440};

   dot_field dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .kill_10     (kill_10),
      .is_dot      (is_dot),
      .is_dots     (is_dots),
      .dot_number  (dot_number),
      .alive_10    (alive_10),
      .alive_count (alive_count),
      .all_eaten   (all_eaten)
   );

   always #5 Clk = ~Clk;

   // Which dot squares contain pixel (x,y): plain integer distance test.
   function automatic logic [9:0] model_hit(input int x, input int y);
      logic [9:0] v = '0;
      for (int i = 0; i < 10; i++) begin
         int ax = (x > cx[i]) ? x - cx[i] : cx[i] - x;
         int ay = (y > cy[i]) ? y - cy[i] : cy[i] - y;
         if (ax <= 3 && ay <= 3) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic int model_index(input logic [9:0] v);
      for (int i = 0; i < 10; i++) if (v[i]) return i;
      return 0;
   endfunction

   // One clock edge with the current inputs, then update the model and settle.
   task automatic tick();
      @(posedge Clk);
      if (!Reset) alive_model = 10'h3FF;
      else        alive_model = alive_model & ~kill_10;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; kill_10 = '0; DrawX = '0; DrawY = '0;
      tick();
      Reset = 1'b1;
      tests++;
      if (alive_10 !== 10'h3FF || alive_count !== 4'd10 || all_eaten !== 1'b0) begin
         fails++;
         $display("FAIL reset: alive=%h count=%0d all_eaten=%b, expected alive=3ff count=10 all_eaten=0",
                  alive_10, alive_count, all_eaten);
      end
      $display("[TB] reset: alive=%h count=%0d", alive_10, alive_count);
   endtask

   task automatic test_hit_points();
      int px [5] = '{320, 323, 324, 1023, 600};
      int py [5] = '{240, 43, 43, 40, 40};
      for (int k = 0; k < 5; k++) begin
         logic [9:0] exp_v;
         DrawX = 10'(px[k]); DrawY = 10'(py[k]);
         #1;
         exp_v = model_hit(px[k], py[k]);
         tests++;
         if (is_dot !== exp_v || is_dots !== (|exp_v) ||
             dot_number !== 4'(model_index(exp_v))) begin
            fails++;
            $display("FAIL hit_point (%0d,%0d): is_dot=%h dots=%b num=%0d, expected %h %b %0d",
                     px[k], py[k], is_dot, is_dots, dot_number, exp_v, |exp_v, model_index(exp_v));
         end
         $display("[TB] hit (%0d,%0d) -> is_dot=%h num=%0d", px[k], py[k], is_dot, dot_number);
      end
   endtask

   task automatic test_single_kill();
      kill_10 = 10'h004;
      tick();
      kill_10 = '0;
      DrawX = 10'd600; DrawY = 10'd40;
      #1;
      tests++;
      if (alive_10 !== alive_model || alive_count !== 4'($countones(alive_model)) ||
          is_dot !== 10'h004 || alive_model !== 10'h3FB) begin
         fails++;
         $display("FAIL single_kill: alive=%h count=%0d is_dot=%h, expected alive=%h count=%0d is_dot=004",
                  alive_10, alive_count, is_dot, alive_model, $countones(alive_model));
      end
      $display("[TB] single kill: alive=%h count=%0d", alive_10, alive_count);
   endtask

   task automatic test_held_kill();
      kill_10 = 10'h004;
      for (int c = 0; c < 50; c++) tick();
      kill_10 = 10'h201;
      tick();
      kill_10 = '0;
      tick();
      tests++;
      if (alive_10 !== 10'h1FA || alive_count !== 4'd7 || alive_10 !== alive_model) begin
         fails++;
         $display("FAIL held_kill: alive=%h count=%0d, expected alive=1fa count=7",
                  alive_10, alive_count);
      end
      $display("[TB] held kill: alive=%h count=%0d", alive_10, alive_count);
   endtask

   task automatic test_reset_beats_kill();
      Reset = 1'b0; kill_10 = 10'h3FF;
      tick();
      Reset = 1'b1; kill_10 = '0;
      #1;
      tests++;
      if (alive_10 !== 10'h3FF || alive_count !== 4'd10) begin
         fails++;
         $display("FAIL reset_vs_kill: alive=%h count=%0d, expected 3ff 10", alive_10, alive_count);
      end
      kill_10 = 10'h3FF;
      tick();
      kill_10 = '0;
      tests++;
      if (alive_10 !== 10'h000 || all_eaten !== 1'b1 || alive_count !== 4'd0) begin
         fails++;
         $display("FAIL kill_all: alive=%h count=%0d all_eaten=%b, expected 000 0 1",
                  alive_10, alive_count, all_eaten);
      end
      $display("[TB] reset beats kill, then kill all: alive=%h eaten=%b", alive_10, all_eaten);
   endtask

   task automatic test_random_kills();
      Reset = 1'b0; kill_10 = '0;
      tick();
      Reset = 1'b1;
      for (int c = 0; c < 60; c++) begin
         Reset   = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
         kill_10 = 10'($urandom & $urandom & $urandom);
         tick();
         tests++;
         if (alive_10 !== alive_model || alive_count !== 4'($countones(alive_model)) ||
             all_eaten !== (alive_model == 10'h000)) begin
            fails++;
            $display("FAIL random_kill %0d: alive=%h count=%0d eaten=%b, expected %h %0d %b",
                     c, alive_10, alive_count, all_eaten, alive_model,
                     $countones(alive_model), alive_model == 10'h000);
         end
         $display("[TB] rand kill %0d: rst=%b kill=%h alive=%h", c, Reset, kill_10, alive_10);
      end
      Reset = 1'b1; kill_10 = '0;
   endtask

   task automatic test_random_coords();
      for (int c = 0; c < 60; c++) begin
         int x, y;
         logic [9:0] exp_v;
         if (c % 2 == 0) begin
            int d = $urandom_range(0, 9);
            x = cx[d] + $urandom_range(0, 10) - 5;
            y = cy[d] + $urandom_range(0, 10) - 5;
         end else begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
         end
         DrawX = 10'(x); DrawY = 10'(y);
         #1;
         exp_v = model_hit(x, y);
         tests++;
         if (is_dot !== exp_v || is_dots !== (|exp_v) ||
             dot_number !== 4'(model_index(exp_v))) begin
            fails++;
            $display("FAIL random_coord (%0d,%0d): is_dot=%h num=%0d, expected %h %0d",
                     x, y, is_dot, dot_number, exp_v, model_index(exp_v));
         end
         $display("[TB] rand coord (%0d,%0d) -> is_dot=%h", x, y, is_dot);
      end
   endtask

   task automatic test_sweep();
      int per_dot [10];
      int offscreen_hits = 0;
      int sweep_fails = 0;
      for (int i = 0; i < 10; i++) per_dot[i] = 0;
      for (int y = 0; y < 525; y++) begin
         for (int x = 0; x < 800; x++) begin
            logic [9:0] exp_v;
            DrawX = 10'(x); DrawY = 10'(y);
            #1;
            exp_v = model_hit(x, y);
            for (int i = 0; i < 10; i++) if (is_dot[i]) per_dot[i]++;
            if (is_dots && (x >= 640 || y >= 480)) offscreen_hits++;
            tests++;
            if (is_dot !== exp_v || dot_number !== 4'(model_index(exp_v))) begin
               fails++;
               sweep_fails++;
               if (sweep_fails <= 10)
                  $display("FAIL sweep (%0d,%0d): is_dot=%h num=%0d, expected %h %0d",
                           x, y, is_dot, dot_number, exp_v, model_index(exp_v));
            end
         end
      end
      for (int i = 0; i < 10; i++) begin
         tests++;
         if (per_dot[i] != 49) begin
            fails++;
            $display("FAIL sweep_area dot %0d: %0d pixels, expected 49", i, per_dot[i]);
         end
      end
      tests++;
      if (offscreen_hits != 0) begin
         fails++;
         $display("FAIL sweep_offscreen: %0d hits, expected 0", offscreen_hits);
      end
      $display("[TB] sweep: %0d pixel mismatches, %0d off-screen hits", sweep_fails, offscreen_hits);
   endtask

   initial begin
      Reset = 1'b1; kill_10 = '0; DrawX = '0; DrawY = '0;
      alive_model = 'x;
      test_reset();
      test_hit_points();
      test_single_kill();
      test_held_kill();
      test_reset_beats_kill();
      test_random_kills();
      test_random_coords();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
